// File: rtl/ifu_fetch_buf_pkg.sv
// rtl/ifu_fetch_buf_pkg.sv - redirect select codes and shared constants for the fetch buffer
package ifu_fetch_buf_pkg;

    typedef enum logic [1:0] {
        IFU_SEL_NORM       = 2'd0,
        IFU_SEL_RELATIVE   = 2'd1,
        IFU_SEL_IRRELATIVE = 2'd2,
        IFU_SEL_REGISTER   = 2'd3
    } ifu_sel_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0000;

endpackage

// File: rtl/ifu_npc.sv
// rtl/ifu_npc.sv - combinational redirect target and misalignment calculation
module ifu_npc
    import ifu_fetch_buf_pkg::*;
(
    input  logic [1:0]  sel_i,
    input  logic [31:0] base_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] reg_i,
    output logic        take_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic [31:0] rel_off;
    logic [5:0]  unused_inst_hi;

    // opcode bits never contribute to a target
    assign unused_inst_hi = inst_i[31:26];
    assign rel_off        = {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
    assign take_o         = (sel_i != IFU_SEL_NORM);

    always_comb begin
        target_o   = base_i;
        misalign_o = 1'b0;
        case (ifu_sel_e'(sel_i))
            IFU_SEL_RELATIVE:   target_o = base_i + 32'd4 + rel_off;
            IFU_SEL_IRRELATIVE: target_o = {base_i[31:28], inst_i[25:0], 2'b00};
            IFU_SEL_REGISTER: begin
                target_o   = {reg_i[31:2], 2'b00};
                misalign_o = (reg_i[1:0] != 2'b00);
            end
            default:            target_o = base_i;
        endcase
    end

endmodule

// File: rtl/ifu_fetch_buf.sv
// rtl/ifu_fetch_buf.sv - decoupled fetch buffer with in-order memory responses and redirect flush
module ifu_fetch_buf
    import ifu_fetch_buf_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          DEPTH    = 4,
    localparam int         PTR_W    = $clog2(DEPTH)
)(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redir_valid,
    input  logic [1:0]  redir_sel,
    input  logic [31:0] redir_base,
    input  logic [31:0] redir_inst,
    input  logic [31:0] redir_reg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        redir_misalign
);

    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d, pend_q, pend_d, drop_q, drop_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic             misalign_q;

    logic             npc_take, npc_misalign, redir_take;
    logic [31:0]      npc_target;
    logic [CNT_W:0]   occupancy;
    logic             req_fire, pop, rsp_drop, rsp_fill;

    ifu_npc u_npc (
        .sel_i      (redir_sel),
        .base_i     (redir_base),
        .inst_i     (redir_inst),
        .reg_i      (redir_reg),
        .take_o     (npc_take),
        .target_o   (npc_target),
        .misalign_o (npc_misalign)
    );

    assign redir_take = redir_valid && npc_take;

    // stale in-flight responses still hold a slot until they drain
    assign occupancy      = {1'b0, count_q} + {1'b0, drop_q};
    assign imem_req_valid = reset && (occupancy < (CNT_W+1)'(DEPTH)) && !redir_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid      = filled_q[rd_q];
    assign out_inst       = inst_mem_q[rd_q];
    assign out_pc         = pc_mem_q[rd_q];
    assign pop            = out_valid && out_ready;
    assign redir_misalign = misalign_q;

    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_fill = imem_rsp_valid && (drop_q == '0) && !redir_take;

    always_comb begin
        pc_d    = pc_q;
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        count_d = count_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        if (redir_take) begin
            pc_d    = npc_target;
            alloc_d = '0;
            fill_d  = '0;
            rd_d    = '0;
            count_d = '0;
            pend_d  = '0;
            // everything still outstanding is stale; a response arriving now is already gone
            drop_d  = drop_q + pend_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d    = pc_q + 32'd4;
                alloc_d = alloc_q + PTR_W'(1);
            end
            if (rsp_drop) drop_d = drop_q - CNT_W'(1);
            if (rsp_fill) fill_d = fill_q + PTR_W'(1);
            if (pop)      rd_d   = rd_q + PTR_W'(1);
            count_d = count_q + CNT_W'(req_fire) - CNT_W'(pop);
            pend_d  = pend_q + CNT_W'(req_fire) - CNT_W'(rsp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            filled_q   <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= IFU_NOP;
            end
        end else begin
            pc_q       <= pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            misalign_q <= redir_take && npc_misalign;
            if (redir_take) begin
                filled_q <= '0;
            end else begin
                if (req_fire) begin
                    pc_mem_q[alloc_q] <= pc_q;
                    filled_q[alloc_q] <= 1'b0;
                end
                if (rsp_fill) begin
                    inst_mem_q[fill_q] <= imem_rsp_data;
                    filled_q[fill_q]   <= 1'b1;
                end
                if (pop) filled_q[rd_q] <= 1'b0;
            end
        end
    end

endmodule
